// File: rtl/sram_stream_pkg.sv
// Shared constants and types for the SRAM line writer/reader pair.
// A line holds four words, packed MSB-first.
package sram_stream_pkg;

   localparam int unsigned ADDR_W         = 19;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned WORDS_PER_LINE = 4;
   localparam int unsigned LINE_W         = WORDS_PER_LINE * WORD_W;
   localparam int unsigned WIDX_W         = $clog2(WORDS_PER_LINE);
   localparam int unsigned LINE_CREDITS   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   // Word 0 is the most significant slice of the line.
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [WIDX_W-1:0] idx);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
         if (idx == WIDX_W'(i)) begin
            w = line[(WORDS_PER_LINE - 1 - i) * WORD_W +: WORD_W];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/sram_stream_reader_if.sv
// SRAM read port plus the outgoing word stream of the line reader.
interface sram_stream_reader_if;
   import sram_stream_pkg::*;

   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_RD_EN;
   logic [LINE_W-1:0] SRAM_DATA_OUT;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output SRAM_ADDR,
      output SRAM_RD_EN,
      input  SRAM_DATA_OUT,
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  SRAM_ADDR,
      input  SRAM_RD_EN,
      output SRAM_DATA_OUT,
      input  word_data,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/sram_line_fifo.sv
// Two-entry line buffer between the SRAM read pipe and the word unpacker.
// Callers never push when full or pop when empty.
module sram_line_fifo
   import sram_stream_pkg::*;
(
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              push,
   input  logic [LINE_W-1:0] push_data,
   input  logic              pop,
   output logic [LINE_W-1:0] head,
   output logic [1:0]        count
);

   logic [LINE_W-1:0] mem_q [2];
   logic [LINE_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q,  count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + 2'(push) - 2'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Reads a contiguous run of SRAM lines and streams them out as words, MSB word first.
// At most two lines are ever buffered or in flight, so the line FIFO cannot overflow.
module sram_stream_reader
   import sram_stream_pkg::*;
#(
   parameter int unsigned RD_LAT = 2
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    num_lines,
   output logic                 busy,
   output logic                 done,
   sram_stream_reader_if.master bus
);

   state_e              state_q,     state_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                rd_en_q,     rd_en_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
   logic [ADDR_W-1:0]   num_lines_q, num_lines_d;
   logic [ADDR_W-1:0]   issued_q,    issued_d;
   logic [ADDR_W-1:0]   drained_q,   drained_d;
   logic [WIDX_W-1:0]   widx_q,      widx_d;
   logic [RD_LAT-1:0]   vpipe_q,     vpipe_d;

   logic [LINE_W-1:0]   head_c;
   logic [1:0]          fifo_count_c;
   logic                push_c;
   logic                word_valid_c;
   logic                accept_c;
   logic                pop_c;
   logic [2:0]          inflight_c;
   logic [2:0]          held_lines_c;
   logic                can_issue_c;

   sram_line_fifo u_line_fifo (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .push      (push_c),
      .push_data (bus.SRAM_DATA_OUT),
      .pop       (pop_c),
      .head      (head_c),
      .count     (fifo_count_c)
   );

   assign push_c       = vpipe_q[RD_LAT-1];
   assign word_valid_c = (fifo_count_c != 2'd0);
   assign accept_c     = word_valid_c && bus.word_ready;
   assign pop_c        = accept_c && (widx_q == WIDX_W'(WORDS_PER_LINE - 1));

   // A line being popped this cycle frees its credit for an issue in the same cycle.
   always_comb begin
      inflight_c = 3'(rd_en_q);
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         inflight_c = inflight_c + 3'(vpipe_q[i]);
      end
      held_lines_c = 3'(fifo_count_c) + inflight_c - 3'(pop_c);
      can_issue_c  = (held_lines_c < 3'(LINE_CREDITS));
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      sram_addr_d = sram_addr_q;
      next_addr_d = next_addr_q;
      num_lines_d = num_lines_q;
      issued_d    = issued_q;
      drained_d   = drained_q;
      widx_d      = widx_q;

      vpipe_d[0] = rd_en_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               num_lines_d = num_lines;
               drained_d   = '0;
               widx_d      = '0;
               // The first read goes out straight from IDLE to save a cycle of latency.
               if (num_lines != '0) begin
                  state_d     = RUN;
                  busy_d      = 1'b1;
                  rd_en_d     = 1'b1;
                  sram_addr_d = base_addr;
                  next_addr_d = base_addr + ADDR_W'(1);
                  issued_d    = ADDR_W'(1);
               end else begin
                  state_d  = FINISH;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  issued_d = '0;
               end
            end
         end

         RUN: begin
            if ((issued_q < num_lines_q) && can_issue_c) begin
               rd_en_d     = 1'b1;
               sram_addr_d = next_addr_q;
               next_addr_d = next_addr_q + ADDR_W'(1);
               issued_d    = issued_q + ADDR_W'(1);
            end
            if (accept_c) begin
               widx_d = widx_q + WIDX_W'(1);
            end
            if (pop_c) begin
               drained_d = drained_q + ADDR_W'(1);
               if (drained_q == (num_lines_q - ADDR_W'(1))) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         sram_addr_q <= '0;
         next_addr_q <= '0;
         num_lines_q <= '0;
         issued_q    <= '0;
         drained_q   <= '0;
         widx_q      <= '0;
         vpipe_q     <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         sram_addr_q <= sram_addr_d;
         next_addr_q <= next_addr_d;
         num_lines_q <= num_lines_d;
         issued_q    <= issued_d;
         drained_q   <= drained_d;
         widx_q      <= widx_d;
         vpipe_q     <= vpipe_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign bus.SRAM_ADDR  = sram_addr_q;
   assign bus.SRAM_RD_EN = rd_en_q;
   assign bus.word_valid = word_valid_c;
   assign bus.word_data  = word_valid_c ? line_word(head_c, widx_q) : '0;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a behavioural SRAM of fixed read latency.
module tb_sram_stream_reader;
   import sram_stream_pkg::*;

   localparam int unsigned RD_LAT = 2;

   logic              CLK = 1'b0;
   logic              RSTn;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] num_lines;
   logic              busy;
   logic              done;

   sram_stream_reader_if bus ();

   sram_stream_reader #(.RD_LAT(RD_LAT)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .start     (start),
      .base_addr (base_addr),
      .num_lines (num_lines),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 CLK = ~CLK;

   // Line contents: 0x10 holds words 1..4, every other line holds A0/A1/A2/A3 tags plus its address.
   function automatic logic [31:0] wexp(input logic [ADDR_W-1:0] a, input int k);
      if (a == 19'h10) return 32'(k + 1);
      return 32'hA000_0000 + (32'(k) << 24) + 32'(a);
   endfunction

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return {wexp(a, 0), wexp(a, 1), wexp(a, 2), wexp(a, 3)};
   endfunction

   // SRAM model: data appears RD_LAT cycles after the strobe cycle.
   logic [LINE_W-1:0] pd [RD_LAT];
   always @(posedge CLK) begin
      pd[0] <= bus.SRAM_RD_EN ? line_of(bus.SRAM_ADDR) : {4{32'hDEAD_BEEF}};
      for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
   end
   assign bus.SRAM_DATA_OUT = pd[RD_LAT-1];

   // Monitor: logs reads and accepted words, checks stall stability and line occupancy.
   int                cyc       = 0;
   int                done_cnt  = 0;
   int                stall_err = 0;
   int                occ_err   = 0;
   int                out_lines = 0;
   int                widx      = 0;
   logic              pv        = 1'b0;
   logic              pr        = 1'b0;
   logic [31:0]       pdat      = '0;
   logic [ADDR_W-1:0] rd_addr [$];
   logic [31:0]       acc_q   [$];
   int                acc_cyc [$];
   logic              acc;
   assign acc = bus.word_valid && bus.word_ready;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (!RSTn) begin
         out_lines <= 0;
         widx      <= 0;
      end else begin
         out_lines <= out_lines + (bus.SRAM_RD_EN ? 1 : 0) - ((acc && widx == 3) ? 1 : 0);
         if (acc) widx <= (widx + 1) % 4;
      end
      if (out_lines > 2) occ_err <= occ_err + 1;
      if (bus.SRAM_RD_EN) rd_addr.push_back(bus.SRAM_ADDR);
      if (acc) begin
         acc_q.push_back(bus.word_data);
         acc_cyc.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (RSTn && pv && !pr && (!bus.word_valid || bus.word_data !== pdat))
         stall_err <= stall_err + 1;
      pv   <= bus.word_valid && RSTn;
      pr   <= bus.word_ready;
      pdat <= bus.word_data;
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      start     = 1'b1;
      base_addr = b;
      num_lines = n;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int k;
      k = 0;
      while (done !== 1'b1 && k < max) begin
         step();
         k++;
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0, r0, d0, s0, o0, m0, k;
      logic [31:0] lit [8];

      RSTn = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0; bus.word_ready = 1'b1;
      repeat (3) step();
      chk("rst_busy",  64'(busy), 0);
      chk("rst_done",  64'(done), 0);
      chk("rst_rden",  64'(bus.SRAM_RD_EN), 0);
      chk("rst_addr",  64'(bus.SRAM_ADDR), 0);
      chk("rst_valid", 64'(bus.word_valid), 0);
      chk("rst_data",  64'(bus.word_data), 0);
      RSTn = 1'b1;
      step();

      // Single line at 0x10: first valid in the 4th cycle after start.
      n0 = acc_q.size(); r0 = rd_addr.size(); d0 = done_cnt;
      launch(19'h10, 19'd1);
      chk("one_busy", 64'(busy), 1);
      chk("one_v0",   64'(bus.word_valid), 0);
      step(); step();
      chk("one_v2",   64'(bus.word_valid), 0);
      step();
      chk("one_v3",   64'(bus.word_valid), 1);
      chk("one_w0",   64'(bus.word_data), 64'h1);
      step(); chk("one_w1", 64'(bus.word_data), 64'h2);
      step(); chk("one_w2", 64'(bus.word_data), 64'h3);
      step(); chk("one_w3", 64'(bus.word_data), 64'h4);
      step();
      chk("one_done",   64'(done), 1);
      chk("one_busy0",  64'(busy), 0);
      chk("one_vend",   64'(bus.word_valid), 0);
      step();
      chk("one_done0",  64'(done), 0);
      chk("one_dcnt",   64'(done_cnt - d0), 1);
      chk("one_reads",  64'(rd_addr.size() - r0), 1);
      chk("one_raddr",  64'(rd_addr[r0]), 64'h10);
      chk("one_nwords", 64'(acc_q.size() - n0), 4);

      // Streaming 8 lines from 0 with ready held high.
      n0 = acc_q.size(); r0 = rd_addr.size(); o0 = occ_err;
      launch(19'h0, 19'd8);
      wait_done("str_done", 200);
      step();
      chk("str_nwords", 64'(acc_q.size() - n0), 32);
      chk("str_nreads", 64'(rd_addr.size() - r0), 8);
      if (acc_q.size() >= n0 + 32) begin
         for (int i = 0; i < 32; i++)
            chk($sformatf("str_w%0d", i), 64'(acc_q[n0+i]), 64'(wexp(ADDR_W'(i / 4), i % 4)));
         chk("str_gapless", 64'(acc_cyc[n0+31] - acc_cyc[n0]), 31);
      end
      if (rd_addr.size() >= r0 + 8) begin
         for (int i = 0; i < 8; i++)
            chk($sformatf("str_a%0d", i), 64'(rd_addr[r0+i]), 64'(i));
      end
      chk("str_occ", 64'(occ_err - o0), 0);

      // Backpressure: 4 lines from 0x100, ready at ~30% duty.
      n0 = acc_q.size(); s0 = stall_err; o0 = occ_err;
      bus.word_ready = 1'b0;
      launch(19'h100, 19'd4);
      k = 0;
      while (done !== 1'b1 && k < 600) begin
         bus.word_ready = ($urandom_range(0, 9) < 3);
         step();
         k++;
      end
      chk("bp_done", 64'(done), 1);
      bus.word_ready = 1'b1;
      step();
      chk("bp_nwords", 64'(acc_q.size() - n0), 16);
      if (acc_q.size() >= n0 + 16) begin
         for (int i = 0; i < 16; i++)
            chk($sformatf("bp_w%0d", i), 64'(acc_q[n0+i]), 64'(wexp(ADDR_W'(19'h100 + i / 4), i % 4)));
      end
      chk("bp_stall", 64'(stall_err - s0), 0);
      chk("bp_occ",   64'(occ_err - o0), 0);

      // Zero length: done the cycle after start, no reads, busy never set.
      r0 = rd_addr.size();
      launch(19'h55, 19'd0);
      chk("zero_done", 64'(done), 1);
      chk("zero_busy", 64'(busy), 0);
      step();
      chk("zero_done0", 64'(done), 0);
      chk("zero_reads", 64'(rd_addr.size() - r0), 0);

      // Start while busy is ignored.
      n0 = acc_q.size(); r0 = rd_addr.size();
      launch(19'h200, 19'd3);
      repeat (5) step();
      start = 1'b1; base_addr = 19'h300; num_lines = 19'd1;
      step();
      start = 1'b0;
      wait_done("bs_done", 200);
      step();
      chk("bs_nwords", 64'(acc_q.size() - n0), 12);
      chk("bs_nreads", 64'(rd_addr.size() - r0), 3);
      if (acc_q.size() >= n0 + 12) begin
         for (int i = 0; i < 12; i++)
            chk($sformatf("bs_w%0d", i), 64'(acc_q[n0+i]), 64'(wexp(ADDR_W'(19'h200 + i / 4), i % 4)));
      end

      // Address wrap from the top line back to 0.
      n0 = acc_q.size(); r0 = rd_addr.size();
      lit[0] = 32'hA007_FFFF; lit[1] = 32'hA107_FFFF; lit[2] = 32'hA207_FFFF; lit[3] = 32'hA307_FFFF;
      lit[4] = 32'hA000_0000; lit[5] = 32'hA100_0000; lit[6] = 32'hA200_0000; lit[7] = 32'hA300_0000;
      launch(19'h7FFFF, 19'd2);
      wait_done("wr_done", 200);
      step();
      chk("wr_nreads", 64'(rd_addr.size() - r0), 2);
      chk("wr_a0", 64'(rd_addr[r0]),   64'h7FFFF);
      chk("wr_a1", 64'(rd_addr[r0+1]), 64'h0);
      chk("wr_nwords", 64'(acc_q.size() - n0), 8);
      if (acc_q.size() >= n0 + 8) begin
         for (int i = 0; i < 8; i++)
            chk($sformatf("wr_w%0d", i), 64'(acc_q[n0+i]), 64'(lit[i]));
      end

      // Reset while the 5th word is presented; no done, no stale words afterwards.
      n0 = acc_q.size(); d0 = done_cnt;
      launch(19'h40, 19'd4);
      k = 0;
      while (acc_q.size() < n0 + 4 && k < 100) begin
         step();
         k++;
      end
      chk("mr_reached", 64'(acc_q.size() - n0), 4);
      RSTn = 1'b0;
      step();
      chk("mr_busy",  64'(busy), 0);
      chk("mr_done",  64'(done), 0);
      chk("mr_rden",  64'(bus.SRAM_RD_EN), 0);
      chk("mr_addr",  64'(bus.SRAM_ADDR), 0);
      chk("mr_valid", 64'(bus.word_valid), 0);
      chk("mr_data",  64'(bus.word_data), 0);
      RSTn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("mr_idle_v%0d", i), 64'(bus.word_valid), 0);
      end
      chk("mr_nodone", 64'(done_cnt - d0), 0);
      m0 = acc_q.size();
      launch(19'h10, 19'd1);
      wait_done("mr2_done", 100);
      step();
      chk("mr2_nwords", 64'(acc_q.size() - m0), 4);
      if (acc_q.size() >= m0 + 4) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("mr2_w%0d", i), 64'(acc_q[m0+i]), 64'(i + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
